// File: rtl/float16_pkg.sv
// Half-precision field layout, value classes and decode helpers
// shared by the float datapath blocks.
package float16_pkg;

   localparam int FP_EW   = 5;
   localparam int FP_MW   = 10;
   localparam int FP_BIAS = 15;
   localparam int FP_EMAX = 31;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      SUB  = 3'd1,
      NORM = 3'd2,
      INF  = 3'd3,
      NAN  = 3'd4
   } fp_class_e;

   typedef struct packed {
      logic             sign;
      fp_class_e        cls;
      logic [FP_MW:0]   sig;
      logic [FP_EW-1:0] eeff;
   } unpack_t;

   function automatic logic [FP_EW-1:0] fp_exp(input logic [15:0] f);
      return f[FP_MW+FP_EW-1:FP_MW];
   endfunction

   function automatic logic [FP_MW-1:0] fp_man(input logic [15:0] f);
      return f[FP_MW-1:0];
   endfunction

   function automatic fp_class_e fp_classify(
      input logic [FP_EW-1:0] e,
      input logic [FP_MW-1:0] m
   );
      fp_class_e c;
      if (e == '0)
         c = (m == '0) ? ZERO : SUB;
      else if (e == FP_EW'(FP_EMAX))
         c = (m == '0) ? INF : NAN;
      else
         c = NORM;
      return c;
   endfunction

endpackage

// File: rtl/fp16_unpack.sv
// Combinational half-precision unpack: class decode, hidden bit,
// and effective exponent (subnormals behave as exponent 1).
module fp16_unpack
   import float16_pkg::*;
(
   input  logic [15:0]      fdata,
   output logic             sign,
   output logic [2:0]       cls,
   output logic [FP_MW:0]   sig,
   output logic [FP_EW-1:0] eeff
);

   logic [FP_EW-1:0] e;
   logic [FP_MW-1:0] m;
   fp_class_e        c;

   always_comb begin
      e    = fp_exp(fdata);
      m    = fp_man(fdata);
      c    = fp_classify(e, m);
      sign = fdata[15];
      cls  = c;
      sig  = {(e != '0), m};
      eeff = (e == '0) ? FP_EW'(1) : e;
   end

endmodule

// File: rtl/float_to_fixed.sv
// Half-precision to signed fixed-point converter: unpack, align,
// then sign/saturate, with a shared-stall valid/ready pipeline.
module float_to_fixed
   import float16_pkg::*;
#(
   parameter int IW = 16,
   parameter int FW = 8
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       fdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IW+FW-1:0]  qdata,
   output logic              ovf,
   output logic              nan,
   output logic              inexact
);

   localparam int W  = IW + FW;
   localparam int XW = W + 1 + 32;

   localparam logic [W:0]   MAG_POS = {2'b00, {(W-1){1'b1}}};
   localparam logic [W:0]   MAG_NEG = {2'b01, {(W-1){1'b0}}};
   localparam logic [W-1:0] Q_MAX   = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] Q_MIN   = {1'b1, {(W-1){1'b0}}};

   logic adv;
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   logic             u_sign;
   logic [2:0]       u_cls;
   logic [FP_MW:0]   u_sig;
   logic [FP_EW-1:0] u_eeff;

   fp16_unpack u_unpack (
      .fdata (fdata),
      .sign  (u_sign),
      .cls   (u_cls),
      .sig   (u_sig),
      .eeff  (u_eeff)
   );

   unpack_t s1_n, s1;
   logic    v1;

   always_comb begin
      s1_n.sign = u_sign;
      s1_n.cls  = fp_class_e'(u_cls);
      s1_n.sig  = u_sig;
      s1_n.eeff = u_eeff;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         s1 <= '0;
      end else if (adv) begin
         v1 <= in_valid;
         s1 <= s1_n;
      end
   end

   logic signed [6:0] sh;
   logic [6:0]        nsh;
   logic [XW-1:0]     wide;
   logic [FP_MW:0]    lost;
   logic [W:0]        mag_n;
   logic              ovfp_n;
   logic              inxp_n;

   // Right shifts also land in the wide field so tiny W still flags overflow.
   always_comb begin
      sh     = 7'(s1.eeff) - 7'(FP_BIAS + FP_MW) + 7'(FW);
      nsh    = -sh;
      wide   = '0;
      lost   = '0;
      inxp_n = 1'b0;
      if (!sh[6]) begin
         wide = XW'(s1.sig) << sh[5:0];
      end else begin
         wide   = XW'(s1.sig >> nsh);
         lost   = s1.sig & ~({(FP_MW+1){1'b1}} << nsh);
         inxp_n = |lost;
      end
      mag_n  = wide[W:0];
      ovfp_n = |wide[XW-1:W+1];
   end

   logic       v2;
   logic       s2_sign;
   fp_class_e  s2_cls;
   logic [W:0] s2_mag;
   logic       s2_ovfp;
   logic       s2_inxp;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         v2      <= 1'b0;
         s2_sign <= 1'b0;
         s2_cls  <= ZERO;
         s2_mag  <= '0;
         s2_ovfp <= 1'b0;
         s2_inxp <= 1'b0;
      end else if (adv) begin
         v2      <= v1;
         s2_sign <= s1.sign;
         s2_cls  <= s1.cls;
         s2_mag  <= mag_n;
         s2_ovfp <= ovfp_n;
         s2_inxp <= inxp_n;
      end
   end

   logic         is_num;
   logic         big;
   logic [W-1:0] q_n;
   logic         ovf_n;
   logic         nan_n;
   logic         inx_n;

   always_comb begin
      is_num = (s2_cls == NORM) || (s2_cls == SUB);
      big    = s2_ovfp | (s2_sign ? (s2_mag > MAG_NEG)
                                  : (s2_mag > MAG_POS));
      q_n    = '0;
      ovf_n  = 1'b0;
      nan_n  = 1'b0;
      inx_n  = 1'b0;
      unique case (1'b1)
         (s2_cls == NAN): nan_n = 1'b1;
         ((s2_cls == INF) || (is_num && big)): begin
            q_n   = s2_sign ? Q_MIN : Q_MAX;
            ovf_n = 1'b1;
         end
         (is_num && !big): begin
            q_n   = s2_sign ? (W'(0) - s2_mag[W-1:0]) : s2_mag[W-1:0];
            inx_n = s2_inxp;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         qdata     <= '0;
         ovf       <= 1'b0;
         nan       <= 1'b0;
         inexact   <= 1'b0;
      end else if (adv) begin
         out_valid <= v2;
         qdata     <= q_n;
         ovf       <= ovf_n;
         nan       <= nan_n;
         inexact   <= inx_n;
      end
   end

endmodule

// File: tb/tb_float_to_fixed.sv
// Directed bench for float_to_fixed at IW=16, FW=8: conversions,
// specials, range edges, backpressure and mid-stream reset.
module tb_float_to_fixed;

   logic        clock = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] fdata;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] qdata;
   logic        ovf;
   logic        nan;
   logic        inexact;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   float_to_fixed #(.IW(16), .FW(8)) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fdata     (fdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .qdata     (qdata),
      .ovf       (ovf),
      .nan       (nan),
      .inexact   (inexact)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // flg = {ovf, nan, inexact}
   task automatic run1(input string tag, input logic [15:0] f,
                       input logic [23:0] q, input logic [2:0] flg);
      @(negedge clock);
      fdata     = f;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
      @(negedge clock);
      in_valid = 1'b0;
      chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
      @(negedge clock);
      chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
      @(negedge clock);
      chk({tag, "_lat3"}, 32'(out_valid), 32'd1);
      chk({tag, "_q"}, 32'(qdata), 32'(q));
      chk({tag, "_flg"}, 32'({ovf, nan, inexact}), 32'(flg));
   endtask

   logic [15:0] bf [8];
   logic [23:0] bq [8];
   int k;
   int got;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      fdata     = 16'h0000;
      #12;
      chk("rst_ov", 32'(out_valid), 32'd0);
      chk("rst_q", 32'(qdata), 32'd0);
      chk("rst_flg", 32'({ovf, nan, inexact}), 32'd0);
      chk("rst_rdy", 32'(in_ready), 32'd1);
      @(negedge clock);
      rst_n = 1'b1;

      run1("one",     16'h3C00, 24'h000100, 3'b000);
      run1("m2p5",    16'hC100, 24'hFFFD80, 3'b000);
      run1("trp",     16'h3555, 24'h000055, 3'b001);
      run1("trn",     16'hB555, 24'hFFFFAB, 3'b001);
      run1("maxh",    16'h7BFF, 24'h7FFFFF, 3'b100);
      run1("pinf",    16'h7C00, 24'h7FFFFF, 3'b100);
      run1("ninf",    16'hFC00, 24'h800000, 3'b100);
      run1("qnan",    16'h7E00, 24'h000000, 3'b010);
      run1("sub",     16'h0001, 24'h000000, 3'b001);
      run1("nzero",   16'h8000, 24'h000000, 3'b000);
      run1("negedge", 16'hF800, 24'h800000, 3'b000);
      run1("posedge", 16'h7800, 24'h7FFFFF, 3'b100);

      bf[0] = 16'h3C00; bq[0] = 24'h000100;
      bf[1] = 16'hC100; bq[1] = 24'hFFFD80;
      bf[2] = 16'h3555; bq[2] = 24'h000055;
      bf[3] = 16'hB555; bq[3] = 24'hFFFFAB;
      bf[4] = 16'h7BFF; bq[4] = 24'h7FFFFF;
      bf[5] = 16'hF800; bq[5] = 24'h800000;
      bf[6] = 16'h7E00; bq[6] = 24'h000000;
      bf[7] = 16'h4000; bq[7] = 24'h000200;
      k   = 0;
      got = 0;
      for (int c = 0; c < 80 && got < 8; c++) begin
         @(negedge clock);
         out_ready = (c % 5) >= 3;
         in_valid  = (k < 8);
         fdata     = (k < 8) ? bf[k] : 16'h0000;
         #1;
         chk("bp_inrdy", 32'(in_ready), 32'(!(out_valid && !out_ready)));
         if (out_valid) begin
            chk("bp_q", 32'(qdata), 32'(bq[got]));
            if (out_ready) got++;
         end
         if (in_valid && in_ready) k++;
      end
      chk("bp_count", 32'(got), 32'd8);
      in_valid = 1'b0;
      @(negedge clock);
      chk("bp_nodup", 32'(out_valid), 32'd0);

      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         in_valid = 1'b1;
         fdata    = bf[i];
      end
      @(negedge clock);
      in_valid = 1'b0;
      chk("rs_full", 32'(out_valid), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rs_ov_async", 32'(out_valid), 32'd0);
      chk("rs_q_async", 32'(qdata), 32'd0);
      @(negedge clock);
      chk("rs_rdy", 32'(in_ready), 32'd1);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("rs_stale", 32'(out_valid), 32'd0);
      end
      run1("post", 16'hC100, 24'hFFFD80, 3'b000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
